// File: rtl/inv_key_expansion.sv
// AES-128 inverse key scheduler: walks round keys r..0 one step per handshake.
// Build option: SBOX_PIPE_EN registers SubWord output and adds a STEP state.
module inv_key_expansion (
   input  logic         clk,
   input  logic         rst_N,
   input  logic [127:0] load_Key,
   input  logic [3:0]   load_Round,
   input  logic         load_Valid,
   output logic         load_Ready,
   output logic         load_Err,
   output logic [127:0] key_Out,
   output logic [3:0]   key_Round,
   output logic         key_Valid,
   input  logic         key_Ready,
   output logic         busy
);

   localparam int BYTE     = 8;
   localparam int WORD     = 32;
   localparam int SENTENCE = 128;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OUT
`ifdef SBOX_PIPE_EN
      ,S_STEP
`endif
   } state_t;

   function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [BYTE-1:0] gmul(input logic [BYTE-1:0] a,
                                            input logic [BYTE-1:0] b);
      logic [BYTE-1:0] r;
      logic [BYTE-1:0] x;
      r = '0;
      x = a;
      for (int i = 0; i < BYTE; i++) begin
         if (b[i]) r = r ^ x;
         x = xtime(x);
      end
      return r;
   endfunction

   // S-box as GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] x);
      logic [BYTE-1:0] p;
      logic [BYTE-1:0] v;
      p = x;
      v = 8'h01;
      for (int k = 1; k < BYTE; k++) begin
         p = gmul(p, p);
         v = gmul(v, p);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [WORD-1:0] rot_word(input logic [WORD-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [BYTE-1:0] rcon(input logic [3:0] r);
      logic [BYTE-1:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   state_t              state;
   state_t              state_n;
   logic [SENTENCE-1:0] key_q;
   logic [3:0]          round_q;
   logic                err_q;
   logic                ld_ok;
   logic                ld_bad;
   logic                out_acc;
   logic                step_do;
   logic [WORD-1:0]     n0, n1, n2, n3;
   logic [WORD-1:0]     p1, p2, p3;
   logic [WORD-1:0]     sub_w;
   logic [WORD-1:0]     sub_use;
   logic [SENTENCE-1:0] next_key;

   assign n0 = key_q[127:96];
   assign n1 = key_q[95:64];
   assign n2 = key_q[63:32];
   assign n3 = key_q[31:0];
   assign p3 = n3 ^ n2;
   assign p2 = n2 ^ n1;
   assign p1 = n1 ^ n0;
   assign sub_w = sub_word(rot_word(p3));

`ifdef SBOX_PIPE_EN
   logic [WORD-1:0] sub_q;

   always_ff @(posedge clk) begin
      if (!rst_N)       sub_q <= '0;
      else if (out_acc) sub_q <= sub_w;
   end

   assign sub_use = sub_q;
   assign step_do = (state == S_STEP);
`else
   assign sub_use = sub_w;
   assign step_do = out_acc;
`endif

   assign next_key = {n0 ^ sub_use ^ {rcon(round_q), 24'h0}, p1, p2, p3};

   assign ld_ok   = (state == S_IDLE) && load_Valid && (load_Round <= 4'd10);
   assign ld_bad  = (state == S_IDLE) && load_Valid && (load_Round > 4'd10);
   assign out_acc = (state == S_OUT) && key_Ready && (round_q != 4'd0);

   always_ff @(posedge clk) begin
      if (!rst_N) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (ld_ok) state_n = S_OUT;
         S_OUT: begin
            if (key_Ready) begin
               if (round_q == 4'd0) state_n = S_IDLE;
`ifdef SBOX_PIPE_EN
               else                 state_n = S_STEP;
`else
               else                 state_n = S_OUT;
`endif
            end
         end
`ifdef SBOX_PIPE_EN
         S_STEP: state_n = S_OUT;
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_N) begin
         key_q   <= '0;
         round_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= ld_bad;
         if (ld_ok) begin
            key_q   <= load_Key;
            round_q <= load_Round;
         end else if (step_do) begin
            key_q   <= next_key;
            round_q <= round_q - 4'd1;
         end
      end
   end

   assign load_Ready = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign key_Valid  = (state == S_OUT);
   assign load_Err   = err_q;
   assign key_Out    = key_q;
   assign key_Round  = round_q;

endmodule
